if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage: holds the PC, fetches from instruction memory through a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode stage.
- Honours the decode stage's hazard freeze and the branch redirect (Br_taken + target).
- Tolerates multi-cycle memory latency: a one-entry skid buffer and a kill state prevent any fetched word from being lost or wrongly issued.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
PC_INC, 4, byte increment between sequential instructions

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
freeze  input  1  hazard stall from decode; hold IF/ID contents
Br_taken  input  1  redirect fetch to Br_addr and flush IF/ID
Br_addr  input  32  absolute branch/jump target byte address
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  transfer completes in a cycle where imem_req=1 and imem_ack=1; may be same-cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
IF_ID_PC  output  32  fetch address of IF_ID_Instruction + PC_INC
IF_ID_Instruction  output  32  instruction to decode; 32'h0 (NOP) when invalid
IF_ID_valid  output  1  IF_ID_Instruction is a real fetched instruction

Behaviour:
- Registers: PC (next fetch address), req_addr, state {REQ, HOLD, KILL}, skid_instr, skid_pc, and IF/ID outputs.
- Reset (rst=1 at clock edge), all other inputs ignored:
  - PC=req_addr=RESET_PC, state=REQ.
  - IF_ID_valid=0, IF_ID_Instruction=0, IF_ID_PC=0, skid cleared.
- imem_req=1 in REQ and KILL, 0 in HOLD; imem_addr=req_addr.
- On an ack in REQ, req_addr is loaded with the next fetch address, so a new request is presented the following cycle.
- Zero-wait memory sustains 1 instruction/cycle; first instruction reaches IF/ID one cycle after its ack.
- Priority each cycle: rst > Br_taken > freeze > normal.
- Br_taken=1:
  - IF_ID_valid<=0, IF_ID_Instruction<=0, skid discarded; PC<=Br_addr.
  - If state=REQ with no ack this cycle: state<=KILL, req_addr unchanged (old request must complete).
  - Otherwise: state<=REQ, req_addr<=Br_addr.
  - Br_taken overrides freeze.
- freeze=1, Br_taken=0:
  - IF/ID outputs hold.
  - REQ with ack: skid<=(imem_rdata, req_addr+PC_INC), PC<=PC+PC_INC, state<=HOLD.
  - REQ without ack: stay REQ.
  - HOLD: stay HOLD.
  - KILL: same as freeze=0.
- freeze=0, Br_taken=0:
  - REQ with ack: IF_ID<=(req_addr+PC_INC, imem_rdata, valid=1), PC<=PC+PC_INC, req_addr<=PC+PC_INC.
  - REQ without ack: IF/ID <= bubble (valid=0, instr=0, PC field 0).
  - HOLD: IF_ID<=(skid_pc, skid_instr, valid=1), req_addr<=PC, state<=REQ.
  - KILL: IF/ID <= bubble; on ack the data is dropped, req_addr<=PC, state<=REQ.
- Br_taken in KILL: PC<=Br_addr, stays KILL until the outstanding ack arrives.
- Arithmetic: 32-bit modulo, PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Skid holds at most one word; a second fetch is never issued while in HOLD.
- Reset mid-request: the outstanding request is abandoned. Memory must tolerate the request drop; the memory is reset by the same rst.

Test Plan:
- Reset, zero-wait memory (ack=1 always, rdata=addr): imem_addr 0,4,8 on consecutive cycles; IF_ID_PC 4,8,12 with instr 0,4,8, valid=1 from cycle 2.
- Memory with 2-cycle latency: imem_addr holds 0 for 3 cycles; IF/ID shows bubbles, then PC=4 instr valid for 1 cycle; throughput 1 per 3 cycles.
- freeze=1 for 3 cycles, zero-wait: IF/ID holds PC=8; next word (addr 8) captured in skid, imem_req=0. On release, IF_ID_PC=12 then 16; no skip or duplicate.
- Br_taken=1, Br_addr=0x100 with zero-wait: next cycle IF_ID_valid=0, instr=0; then imem_addr=0x100, following IF_ID_PC=0x104.
- Br_taken mid 3-cycle request at addr 0x20: imem_addr stays 0x20 until ack; that word never reaches IF/ID; next request addr=Br_addr.
- Br_taken and freeze both 1 while in HOLD: skid discarded, IF/ID flushed, fetch restarts at Br_addr; rst mid-request returns to PC=RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/acknowledge bus between the fetch stage and instruction memory
// Signals:
//   imem_req   - fetch request valid (fetch stage -> memory)
//   imem_addr  - fetch byte address, stable while imem_req=1 and imem_ack=0
//   imem_ack   - transfer completes in a cycle with imem_req=1 and imem_ack=1 (may be same cycle)
//   imem_rdata - instruction word, valid when imem_ack=1
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC, req/ack memory fetch, one-entry skid buffer and IF/ID register
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   freeze            - decode hazard stall, IF/ID contents hold
//   Br_taken, Br_addr - redirect fetch to Br_addr and flush IF/ID
//   imem              - instruction-memory bus (master side)
//   IF_ID_PC          - fetch address of IF_ID_Instruction plus PC_INC
//   IF_ID_Instruction - instruction for decode, 0 when not valid
//   IF_ID_valid       - IF_ID_Instruction is a real fetched instruction
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_addr,
  if_stage_if.master  imem,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_valid
);
  typedef enum logic [1:0] {REQ, HOLD, KILL} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fire;
  assign imem.imem_req     = state_q != HOLD;
  assign imem.imem_addr    = addr_q;
  assign fire              = imem.imem_req && imem.imem_ack;
  assign IF_ID_PC          = ifid_pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_valid       = ifid_valid_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (Br_taken) begin
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      pc_d         = Br_addr;
      // A request already on the bus must be allowed to complete before the new target is issued
      if (state_q != HOLD && !fire) state_d = KILL;
      else begin
        state_d = REQ;
        addr_d  = Br_addr;
      end
    end else if (state_q == KILL) begin
      // Wrong-path word: drop it and restart at the redirected PC
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
      if (fire) begin
        state_d = REQ;
        addr_d  = pc_q;
      end
    end else if (state_q == HOLD) begin
      if (!freeze) begin
        ifid_pc_d    = skid_pc_q;
        ifid_instr_d = skid_instr_q;
        ifid_valid_d = 1'b1;
        addr_d       = pc_q;
        state_d      = REQ;
      end
    end else if (fire) begin
      pc_d   = pc_q + PC_INC;
      addr_d = pc_q + PC_INC;
      // Decode cannot take the word yet, so park it and stop fetching
      if (freeze) begin
        skid_instr_d = imem.imem_rdata;
        skid_pc_d    = addr_q + PC_INC;
        state_d      = HOLD;
      end else begin
        ifid_pc_d    = addr_q + PC_INC;
        ifid_instr_d = imem.imem_rdata;
        ifid_valid_d = 1'b1;
      end
    end else if (!freeze) begin
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch-stage bench with a program-order reference model and variable-latency memory
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, freeze, Br_taken;
  logic [31:0] Br_addr;
  logic [31:0] IF_ID_PC, IF_ID_Instruction;
  logic        IF_ID_valid;
  int          n_chk = 0, n_fail = 0;
  int          cnt = 0;
  logic [1:0]  fix_lat, rnd_lat = 2'd0;
  logic        rnd_mode;
  logic        p_v, p_req, p_ack;
  logic [31:0] p_pc, p_in, p_addr;
  logic [31:0] exp_pc;
  int          idle;
  if_stage_if bus();
  if_stage #(.RESET_PC(32'h0), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Br_taken(Br_taken), .Br_addr(Br_addr),
    .imem(bus), .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_valid(IF_ID_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction
  always @(posedge clk) begin
    cnt <= (rst || !bus.imem_req || bus.imem_ack) ? 0 : cnt + 1;
    if (bus.imem_ack) rnd_lat <= 2'($urandom_range(0, 3));
  end
  assign bus.imem_ack   = bus.imem_req && (cnt >= int'(rnd_mode ? rnd_lat : fix_lat));
  assign bus.imem_rdata = mem(bus.imem_addr);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic f, input logic b, input logic [31:0] ba, input logic r);
    freeze = f; Br_taken = b; Br_addr = ba; rst = r;
    #1;
    p_v = IF_ID_valid; p_pc = IF_ID_PC; p_in = IF_ID_Instruction;
    p_req = bus.imem_req; p_ack = bus.imem_ack; p_addr = bus.imem_addr;
    @(posedge clk);
    #1;
    if (r) begin
      check("rst_valid", IF_ID_valid, 0);
      check("rst_instr", IF_ID_Instruction, 0);
      check("rst_pc", IF_ID_PC, 0);
      check("rst_addr", bus.imem_addr, 0);
      check("rst_req", bus.imem_req, 1);
      exp_pc = 32'h0;
      idle = 0;
    end else begin
      if (p_v && !f && !b) begin
        check("seq_pc", p_pc, exp_pc + 32'd4);
        check("seq_instr", p_in, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else if (f || b) idle = 0;
      else idle++;
      if (b) begin
        check("flush_valid", IF_ID_valid, 0);
        check("flush_instr", IF_ID_Instruction, 0);
        exp_pc = ba;
      end else if (f) begin
        check("hold_valid", IF_ID_valid, p_v);
        check("hold_pc", IF_ID_PC, p_pc);
        check("hold_instr", IF_ID_Instruction, p_in);
      end
      if (p_req && !p_ack && bus.imem_req) check("addr_stable", bus.imem_addr, p_addr);
      if (!IF_ID_valid) check("bubble_instr", IF_ID_Instruction, 0);
      if (idle == 20) check("stall", idle, 0);
    end
  endtask
  initial begin
    rnd_mode = 1'b0; fix_lat = 2'd0; exp_pc = 32'h0; idle = 0;
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("z_addr0", p_addr, 32'h0); check("z_pc0", IF_ID_PC, 32'h4); check("z_v0", IF_ID_valid, 1);
    check("z_in0", IF_ID_Instruction, mem(32'h0));
    cyc(0, 0, 0, 0);
    check("z_addr1", p_addr, 32'h4); check("z_pc1", IF_ID_PC, 32'h8);
    cyc(0, 0, 0, 0);
    check("z_addr2", p_addr, 32'h8); check("z_pc2", IF_ID_PC, 32'hC);
    cyc(1, 0, 0, 0);
    check("frz_pc", IF_ID_PC, 32'hC); check("frz_req", bus.imem_req, 0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    check("frz_pc3", IF_ID_PC, 32'hC); check("frz_req3", bus.imem_req, 0);
    cyc(0, 0, 0, 0);
    check("rel_pc0", IF_ID_PC, 32'h10); check("rel_in0", IF_ID_Instruction, mem(32'hC));
    check("rel_addr", bus.imem_addr, 32'h10);
    cyc(0, 0, 0, 0);
    check("rel_pc1", IF_ID_PC, 32'h14);
    cyc(0, 1, 32'h100, 0);
    check("br_addr", bus.imem_addr, 32'h100);
    cyc(0, 0, 0, 0);
    check("br_pc", IF_ID_PC, 32'h104); check("br_v", IF_ID_valid, 1);
    cyc(0, 1, 32'hFFFF_FFF8, 0);
    cyc(0, 0, 0, 0); check("wrap0", IF_ID_PC, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0); check("wrap1", IF_ID_PC, 32'h0);
    cyc(0, 0, 0, 0); check("wrap2", IF_ID_PC, 32'h4);
    cyc(0, 1, 32'h20, 0);
    fix_lat = 2'd2;
    cyc(0, 1, 32'h40, 0);
    check("kill_addr0", bus.imem_addr, 32'h20); check("kill_req", bus.imem_req, 1);
    cyc(0, 0, 0, 0);
    check("kill_addr1", bus.imem_addr, 32'h20); check("kill_v1", IF_ID_valid, 0);
    cyc(0, 0, 0, 0);
    check("kill_new", bus.imem_addr, 32'h40); check("kill_v2", IF_ID_valid, 0);
    cyc(0, 0, 0, 0); check("lat_v0", IF_ID_valid, 0);
    cyc(0, 0, 0, 0); check("lat_v1", IF_ID_valid, 0);
    cyc(0, 0, 0, 0); check("lat_v2", IF_ID_valid, 1); check("lat_pc", IF_ID_PC, 32'h44);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); check("lat_gap", IF_ID_valid, 0);
    cyc(0, 0, 0, 0); check("lat_pc2", IF_ID_PC, 32'h48);
    fix_lat = 2'd0;
    cyc(1, 0, 0, 0);
    check("hold_req", bus.imem_req, 0);
    cyc(1, 1, 32'h200, 0);
    check("hbr_addr", bus.imem_addr, 32'h200); check("hbr_req", bus.imem_req, 1);
    cyc(0, 0, 0, 0);
    check("hbr_pc", IF_ID_PC, 32'h204); check("hbr_in", IF_ID_Instruction, mem(32'h200));
    fix_lat = 2'd3;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    fix_lat = 2'd0;
    cyc(0, 0, 0, 0);
    check("rst_mid_pc", IF_ID_PC, 32'h4); check("rst_mid_in", IF_ID_Instruction, mem(32'h0));
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ba;
      ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, ba, $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
